// File: rtl/mips32i_single_cycle.sv
// Single-cycle MIPS32 integer core: one instruction per rising edge. Instruction and data
// memory are read combinationally; the core does load sign-extension and register writeback.
module mips32i_single_cycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_in,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [31:0] address_out,
  output logic        mem_wt_en,
  output logic        mem_rd_en,
  output logic [1:0]  mem_size_sel,
  output logic [31:0] PC_out
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20, OP_LH    = 6'h21, OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24, OP_LHU   = 6'h25, OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29, OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08, F_JALR = 6'h09, F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27, F_SLT  = 6'h2A, F_SLTU = 6'h2B;

  localparam logic [1:0] SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b11;

  logic [31:0] pc_q, pc_d;
  logic [31:0] regs_q [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] index26;

  logic [31:0] rs_val, rt_val, sext_imm, zext_imm;
  logic [31:0] pc_plus4, branch_target, jump_target;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mem_rd, mem_wt;
  logic [1:0]  mem_size;

  assign opcode  = inst_in[31:26];
  assign rs      = inst_in[25:21];
  assign rt      = inst_in[20:16];
  assign rd      = inst_in[15:11];
  assign shamt   = inst_in[10:6];
  assign funct   = inst_in[5:0];
  assign imm16   = inst_in[15:0];
  assign index26 = inst_in[25:0];

  assign rs_val   = (rs == 5'd0) ? 32'h0 : regs_q[rs];
  assign rt_val   = (rt == 5'd0) ? 32'h0 : regs_q[rt];
  assign sext_imm = {{16{imm16[15]}}, imm16};
  assign zext_imm = {16'h0, imm16};

  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = pc_plus4 + {sext_imm[29:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], index26, 2'b00};

  // Effective address is always formed; only the strobes say whether memory uses it.
  assign address_out  = rs_val + sext_imm;
  assign data_out     = rt_val;
  assign mem_wt_en    = mem_wt;
  assign mem_rd_en    = mem_rd;
  assign mem_size_sel = mem_size;
  assign PC_out       = pc_q;

  always_comb begin
    // NOTE: every decode output is defaulted first so no path through the case infers a latch.
    pc_d     = pc_plus4;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = 32'h0;
    mem_rd   = 1'b0;
    mem_wt   = 1'b0;
    mem_size = SIZE_WORD;

    case (opcode)
      OP_RTYPE: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        case (funct)
          F_SLL:         rf_wdata = rt_val << shamt;
          F_SRL:         rf_wdata = rt_val >> shamt;
          F_SRA:         rf_wdata = $signed(rt_val) >>> shamt;
          F_SLLV:        rf_wdata = rt_val << rs_val[4:0];
          F_SRLV:        rf_wdata = rt_val >> rs_val[4:0];
          F_SRAV:        rf_wdata = $signed(rt_val) >>> rs_val[4:0];
          F_JR: begin
            rf_we = 1'b0;
            pc_d  = rs_val;
          end
          F_JALR: begin
            rf_wdata = pc_plus4;
            pc_d     = rs_val;
          end
          F_ADD, F_ADDU: rf_wdata = rs_val + rt_val;
          F_SUB, F_SUBU: rf_wdata = rs_val - rt_val;
          F_AND:         rf_wdata = rs_val & rt_val;
          F_OR:          rf_wdata = rs_val | rt_val;
          F_XOR:         rf_wdata = rs_val ^ rt_val;
          F_NOR:         rf_wdata = ~(rs_val | rt_val);
          F_SLT:         rf_wdata = {31'h0, $signed(rs_val) < $signed(rt_val)};
          F_SLTU:        rf_wdata = {31'h0, rs_val < rt_val};
          default:       rf_we = 1'b0;
        endcase
      end
      OP_J:   pc_d = jump_target;
      OP_JAL: begin
        pc_d     = jump_target;
        rf_we    = 1'b1;
        rf_waddr = 5'd31;
        rf_wdata = pc_plus4;
      end
      OP_BEQ:  if (rs_val == rt_val) pc_d = branch_target;
      OP_BNE:  if (rs_val != rt_val) pc_d = branch_target;
      OP_BLEZ: if ($signed(rs_val) <= 0) pc_d = branch_target;
      OP_BGTZ: if ($signed(rs_val) > 0) pc_d = branch_target;
      OP_ADDI, OP_ADDIU: begin rf_we = 1'b1; rf_wdata = rs_val + sext_imm; end
      OP_SLTI:  begin rf_we = 1'b1; rf_wdata = {31'h0, $signed(rs_val) < $signed(sext_imm)}; end
      OP_SLTIU: begin rf_we = 1'b1; rf_wdata = {31'h0, rs_val < sext_imm}; end
      OP_ANDI:  begin rf_we = 1'b1; rf_wdata = rs_val & zext_imm; end
      OP_ORI:   begin rf_we = 1'b1; rf_wdata = rs_val | zext_imm; end
      OP_XORI:  begin rf_we = 1'b1; rf_wdata = rs_val ^ zext_imm; end
      OP_LUI:   begin rf_we = 1'b1; rf_wdata = {imm16, 16'h0}; end
      // Memory returns lane-aligned, zero-extended data; only signed loads need extension.
      OP_LB: begin
        mem_rd = 1'b1; mem_size = SIZE_BYTE; rf_we = 1'b1;
        rf_wdata = {{24{data_in[7]}}, data_in[7:0]};
      end
      OP_LH: begin
        mem_rd = 1'b1; mem_size = SIZE_HALF; rf_we = 1'b1;
        rf_wdata = {{16{data_in[15]}}, data_in[15:0]};
      end
      OP_LBU: begin mem_rd = 1'b1; mem_size = SIZE_BYTE; rf_we = 1'b1; rf_wdata = data_in; end
      OP_LHU: begin mem_rd = 1'b1; mem_size = SIZE_HALF; rf_we = 1'b1; rf_wdata = data_in; end
      OP_LW:  begin mem_rd = 1'b1; mem_size = SIZE_WORD; rf_we = 1'b1; rf_wdata = data_in; end
      OP_SB:  begin mem_wt = 1'b1; mem_size = SIZE_BYTE; end
      OP_SH:  begin mem_wt = 1'b1; mem_size = SIZE_HALF; end
      OP_SW:  begin mem_wt = 1'b1; mem_size = SIZE_WORD; end
      default: ;
    endcase

    if (rst) begin
      rf_we  = 1'b0;
      mem_rd = 1'b0;
      mem_wt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so PC and register file both update from pre-edge values.
    if (rst) begin
      pc_q <= RESET_PC;
      // NOTE: clearing every entry on reset keeps the register file in flops, never a RAM macro.
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
    end else begin
      pc_q <= pc_d;
      if (rf_we && (rf_waddr != 5'd0)) regs_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_mips32i_single_cycle.sv
// Directed bench for mips32i_single_cycle: drives instructions directly on inst_in and
// models a little-endian byte-addressed data memory that writes on the falling edge.
module tb_mips32i_single_cycle;

  localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_BLEZ = 6'h06, OP_BGTZ = 6'h07, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LB = 6'h20, OP_LH = 6'h21;
  localparam logic [5:0] OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25, OP_SB = 6'h28;
  localparam logic [5:0] OP_SH = 6'h29, OP_SW = 6'h2B;
  localparam logic [5:0] F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04, F_SRLV = 6'h06;
  localparam logic [5:0] F_JR = 6'h08, F_JALR = 6'h09, F_ADD = 6'h20, F_SUB = 6'h22;
  localparam logic [5:0] F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_in = NOP;
  logic [31:0] data_in, data_out, address_out, PC_out;
  logic        mem_wt_en, mem_rd_en;
  logic [1:0]  mem_size_sel;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] dmem [0:1023] = '{default: 8'h00};
  logic [9:0] maddr;
  assign maddr = address_out[9:0];

  always #5 clk = ~clk;

  mips32i_single_cycle #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_in      (inst_in),
    .data_in      (data_in),
    .data_out     (data_out),
    .address_out  (address_out),
    .mem_wt_en    (mem_wt_en),
    .mem_rd_en    (mem_rd_en),
    .mem_size_sel (mem_size_sel),
    .PC_out       (PC_out)
  );

  always_comb begin
    case (mem_size_sel)
      2'b00:   data_in = {24'h0, dmem[maddr]};
      2'b01:   data_in = {16'h0, dmem[maddr + 10'd1], dmem[maddr]};
      default: data_in = {dmem[maddr + 10'd3], dmem[maddr + 10'd2], dmem[maddr + 10'd1], dmem[maddr]};
    endcase
  end

  always @(negedge clk) begin
    if (mem_wt_en) begin
      dmem[maddr] <= data_out[7:0];
      if (mem_size_sel != 2'b00) dmem[maddr + 10'd1] <= data_out[15:8];
      if (mem_size_sel == 2'b11) begin
        dmem[maddr + 10'd2] <= data_out[23:16];
        dmem[maddr + 10'd3] <= data_out[31:24];
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] rs_f, rt_f, rd_f, sh);
    return {6'h00, rs_f, rt_f, rd_f, sh, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs_f, rt_f,
                                        input logic [15:0] imm);
    return {op, rs_f, rt_f, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic present(input logic [31:0] instr);
    inst_in = instr;
    #1;
  endtask

  task automatic clock_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [31:0] instr);
    present(instr);
    clock_edge();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inst_in = NOP;
    clock_edge();
    rst = 1'b0;
  endtask

  // Observes a register through the store-data port using a scratch SW at 0x300.
  task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
    present(enc_i(OP_SW, 5'd0, r, 16'h0300));
    v = data_out;
    clock_edge();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (PC_out !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", PC_out, 32'h0); end
    present(NOP);
    n_vec++; if (mem_wt_en !== 1'b0 || mem_rd_en !== 1'b0) begin n_err++; $display("FAIL idle_strobes: got wt=%b rd=%b want 0 0", mem_wt_en, mem_rd_en); end
    n_vec++; if (mem_size_sel !== 2'b11) begin n_err++; $display("FAIL idle_size: got %b want 11", mem_size_sel); end
    clock_edge();
    n_vec++; if (PC_out !== 32'h4) begin n_err++; $display("FAIL nop_pc: got %h want %h", PC_out, 32'h4); end
  endtask

  task automatic test_alu();
    logic [31:0] v;
    do_reset();
    run(enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5));
    run(enc_i(OP_ADDI, 5'd0, 5'd2, 16'hFFFD));
    run(enc_r(F_ADD, 5'd1, 5'd2, 5'd3, 5'd0));
    run(enc_r(F_SUB, 5'd2, 5'd1, 5'd4, 5'd0));
    run(enc_r(F_SLT, 5'd2, 5'd1, 5'd5, 5'd0));
    run(enc_r(F_SLTU, 5'd2, 5'd1, 5'd6, 5'd0));
    run(enc_i(OP_SLTIU, 5'd2, 5'd7, 16'hFFFF));
    run(enc_i(OP_SLTI, 5'd2, 5'd8, 16'hFFFE));
    run(enc_i(OP_LUI, 5'd0, 5'd9, 16'h7FFF));
    run(enc_i(OP_ORI, 5'd9, 5'd9, 16'hFFFF));
    run(enc_i(OP_ADDI, 5'd9, 5'd9, 16'd1));
    n_vec++; if (PC_out !== 32'h2C) begin n_err++; $display("FAIL alu_pc: got %h want %h", PC_out, 32'h2C); end
    read_reg(5'd3, v);
    n_vec++; if (v !== 32'h2) begin n_err++; $display("FAIL add: got %h want %h", v, 32'h2); end
    read_reg(5'd4, v);
    n_vec++; if (v !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL sub: got %h want %h", v, 32'hFFFF_FFF8); end
    read_reg(5'd5, v);
    n_vec++; if (v !== 32'h1) begin n_err++; $display("FAIL slt: got %h want %h", v, 32'h1); end
    read_reg(5'd6, v);
    n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL sltu: got %h want %h", v, 32'h0); end
    read_reg(5'd7, v);
    n_vec++; if (v !== 32'h1) begin n_err++; $display("FAIL sltiu_sext: got %h want %h", v, 32'h1); end
    read_reg(5'd8, v);
    n_vec++; if (v !== 32'h1) begin n_err++; $display("FAIL slti: got %h want %h", v, 32'h1); end
    read_reg(5'd9, v);
    n_vec++; if (v !== 32'h8000_0000) begin n_err++; $display("FAIL addi_wrap: got %h want %h", v, 32'h8000_0000); end
  endtask

  task automatic test_logic_shift();
    logic [31:0] v;
    do_reset();
    run(enc_i(OP_ORI, 5'd0, 5'd1, 16'h8000));
    run(enc_i(OP_LUI, 5'd0, 5'd2, 16'h8000));
    run(enc_r(F_SRA, 5'd0, 5'd2, 5'd3, 5'd4));
    run(enc_r(F_SRL, 5'd0, 5'd2, 5'd4, 5'd4));
    run(enc_r(F_NOR, 5'd0, 5'd0, 5'd5, 5'd0));
    run(enc_i(OP_ADDI, 5'd0, 5'd0, 16'd7));
    run(enc_i(OP_ADDI, 5'd0, 5'd7, 16'd36));
    run(enc_r(F_SLLV, 5'd7, 5'd1, 5'd6, 5'd0));
    run(enc_i(OP_XORI, 5'd5, 5'd8, 16'hFFFF));
    run(enc_i(OP_ANDI, 5'd5, 5'd10, 16'h8000));
    run(enc_r(F_SRLV, 5'd7, 5'd5, 5'd11, 5'd0));
    read_reg(5'd1, v);
    n_vec++; if (v !== 32'h0000_8000) begin n_err++; $display("FAIL ori_zext: got %h want %h", v, 32'h0000_8000); end
    read_reg(5'd3, v);
    n_vec++; if (v !== 32'hF800_0000) begin n_err++; $display("FAIL sra: got %h want %h", v, 32'hF800_0000); end
    read_reg(5'd4, v);
    n_vec++; if (v !== 32'h0800_0000) begin n_err++; $display("FAIL srl: got %h want %h", v, 32'h0800_0000); end
    read_reg(5'd5, v);
    n_vec++; if (v !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL nor: got %h want %h", v, 32'hFFFF_FFFF); end
    read_reg(5'd0, v);
    n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL r0_write: got %h want %h", v, 32'h0); end
    read_reg(5'd6, v);
    n_vec++; if (v !== 32'h0008_0000) begin n_err++; $display("FAIL sllv_mask: got %h want %h", v, 32'h0008_0000); end
    read_reg(5'd8, v);
    n_vec++; if (v !== 32'hFFFF_0000) begin n_err++; $display("FAIL xori: got %h want %h", v, 32'hFFFF_0000); end
    read_reg(5'd10, v);
    n_vec++; if (v !== 32'h0000_8000) begin n_err++; $display("FAIL andi: got %h want %h", v, 32'h0000_8000); end
    read_reg(5'd11, v);
    n_vec++; if (v !== 32'h0FFF_FFFF) begin n_err++; $display("FAIL srlv: got %h want %h", v, 32'h0FFF_FFFF); end
  endtask

  task automatic test_memory();
    logic [31:0] v;
    do_reset();
    run(enc_i(OP_LUI, 5'd0, 5'd1, 16'h1234));
    run(enc_i(OP_ORI, 5'd1, 5'd1, 16'h5687));
    present(enc_i(OP_SW, 5'd0, 5'd1, 16'h0000));
    n_vec++; if (mem_wt_en !== 1'b1 || mem_rd_en !== 1'b0) begin n_err++; $display("FAIL sw_strobes: got wt=%b rd=%b want 1 0", mem_wt_en, mem_rd_en); end
    n_vec++; if (mem_size_sel !== 2'b11) begin n_err++; $display("FAIL sw_size: got %b want 11", mem_size_sel); end
    n_vec++; if (address_out !== 32'h0) begin n_err++; $display("FAIL sw_addr: got %h want %h", address_out, 32'h0); end
    n_vec++; if (data_out !== 32'h1234_5687) begin n_err++; $display("FAIL sw_data: got %h want %h", data_out, 32'h1234_5687); end
    clock_edge();
    n_vec++; if (dmem[0] !== 8'h87 || dmem[3] !== 8'h12) begin n_err++; $display("FAIL sw_mem: got %h/%h want 87/12", dmem[0], dmem[3]); end
    run(enc_i(OP_LB, 5'd0, 5'd2, 16'd0));
    run(enc_i(OP_LBU, 5'd0, 5'd3, 16'd0));
    present(enc_i(OP_LH, 5'd0, 5'd4, 16'd2));
    n_vec++; if (mem_rd_en !== 1'b1 || mem_wt_en !== 1'b0 || mem_size_sel !== 2'b01) begin n_err++; $display("FAIL lh_ctrl: got rd=%b wt=%b size=%b want 1 0 01", mem_rd_en, mem_wt_en, mem_size_sel); end
    n_vec++; if (address_out !== 32'h2) begin n_err++; $display("FAIL lh_addr: got %h want %h", address_out, 32'h2); end
    clock_edge();
    run(enc_i(OP_SB, 5'd0, 5'd1, 16'd5));
    run(enc_i(OP_LW, 5'd0, 5'd5, 16'd4));
    run(enc_i(OP_SH, 5'd0, 5'd5, 16'd8));
    run(enc_i(OP_LH, 5'd0, 5'd7, 16'd8));
    run(enc_i(OP_LHU, 5'd0, 5'd8, 16'd8));
    run(enc_i(OP_ADDI, 5'd0, 5'd9, 16'h0020));
    present(enc_i(OP_LW, 5'd9, 5'd10, 16'hFFFC));
    n_vec++; if (address_out !== 32'h1C) begin n_err++; $display("FAIL neg_offset_addr: got %h want %h", address_out, 32'h1C); end
    clock_edge();
    read_reg(5'd2, v);
    n_vec++; if (v !== 32'hFFFF_FF87) begin n_err++; $display("FAIL lb_sext: got %h want %h", v, 32'hFFFF_FF87); end
    read_reg(5'd3, v);
    n_vec++; if (v !== 32'h0000_0087) begin n_err++; $display("FAIL lbu: got %h want %h", v, 32'h0000_0087); end
    read_reg(5'd4, v);
    n_vec++; if (v !== 32'h0000_1234) begin n_err++; $display("FAIL lh_pos: got %h want %h", v, 32'h0000_1234); end
    read_reg(5'd5, v);
    n_vec++; if (v !== 32'h0000_8700) begin n_err++; $display("FAIL sb_lw: got %h want %h", v, 32'h0000_8700); end
    read_reg(5'd7, v);
    n_vec++; if (v !== 32'hFFFF_8700) begin n_err++; $display("FAIL lh_sext: got %h want %h", v, 32'hFFFF_8700); end
    read_reg(5'd8, v);
    n_vec++; if (v !== 32'h0000_8700) begin n_err++; $display("FAIL lhu: got %h want %h", v, 32'h0000_8700); end
  endtask

  task automatic test_branches();
    do_reset();
    run(enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1));
    run(enc_i(OP_ADDI, 5'd0, 5'd2, 16'd1));
    run(NOP);
    run(NOP);
    n_vec++; if (PC_out !== 32'h10) begin n_err++; $display("FAIL pre_beq_pc: got %h want %h", PC_out, 32'h10); end
    run(enc_i(OP_BEQ, 5'd1, 5'd2, 16'd2));
    n_vec++; if (PC_out !== 32'h1C) begin n_err++; $display("FAIL beq_taken: got %h want %h", PC_out, 32'h1C); end
    run(enc_i(OP_BNE, 5'd1, 5'd2, 16'd5));
    n_vec++; if (PC_out !== 32'h20) begin n_err++; $display("FAIL bne_not_taken: got %h want %h", PC_out, 32'h20); end
    run(enc_i(OP_BLEZ, 5'd0, 5'd0, 16'd3));
    n_vec++; if (PC_out !== 32'h30) begin n_err++; $display("FAIL blez_zero: got %h want %h", PC_out, 32'h30); end
    run(enc_i(OP_BGTZ, 5'd0, 5'd0, 16'd3));
    n_vec++; if (PC_out !== 32'h34) begin n_err++; $display("FAIL bgtz_zero: got %h want %h", PC_out, 32'h34); end
    run(enc_i(OP_ADDI, 5'd0, 5'd3, 16'd2));
    run(enc_i(OP_BNE, 5'd1, 5'd3, 16'hFFFC));
    n_vec++; if (PC_out !== 32'h2C) begin n_err++; $display("FAIL bne_backward: got %h want %h", PC_out, 32'h2C); end
    run(enc_i(OP_BGTZ, 5'd1, 5'd0, 16'd1));
    n_vec++; if (PC_out !== 32'h34) begin n_err++; $display("FAIL bgtz_pos: got %h want %h", PC_out, 32'h34); end
    run(enc_i(OP_ADDI, 5'd0, 5'd4, 16'hFFFF));
    run(enc_i(OP_BLEZ, 5'd4, 5'd0, 16'd2));
    n_vec++; if (PC_out !== 32'h44) begin n_err++; $display("FAIL blez_neg: got %h want %h", PC_out, 32'h44); end
    run(enc_i(OP_BEQ, 5'd1, 5'd3, 16'd7));
    n_vec++; if (PC_out !== 32'h48) begin n_err++; $display("FAIL beq_not_taken: got %h want %h", PC_out, 32'h48); end
  endtask

  task automatic test_jumps();
    logic [31:0] v;
    do_reset();
    for (int i = 0; i < 8; i++) run(NOP);
    run(enc_j(OP_JAL, 26'h40));
    n_vec++; if (PC_out !== 32'h100) begin n_err++; $display("FAIL jal_pc: got %h want %h", PC_out, 32'h100); end
    run(enc_r(F_JR, 5'd31, 5'd0, 5'd0, 5'd0));
    n_vec++; if (PC_out !== 32'h24) begin n_err++; $display("FAIL jr_pc: got %h want %h", PC_out, 32'h24); end
    run(enc_r(F_JALR, 5'd31, 5'd0, 5'd5, 5'd0));
    n_vec++; if (PC_out !== 32'h24) begin n_err++; $display("FAIL jalr_pc: got %h want %h", PC_out, 32'h24); end
    run(enc_j(OP_J, 26'h3FF_FFFF));
    n_vec++; if (PC_out !== 32'h0FFF_FFFC) begin n_err++; $display("FAIL j_max_index: got %h want %h", PC_out, 32'h0FFF_FFFC); end
    run(enc_j(OP_J, 26'h10));
    n_vec++; if (PC_out !== 32'h1000_0040) begin n_err++; $display("FAIL j_region: got %h want %h", PC_out, 32'h1000_0040); end
    read_reg(5'd31, v);
    n_vec++; if (v !== 32'h24) begin n_err++; $display("FAIL jal_link: got %h want %h", v, 32'h24); end
    read_reg(5'd5, v);
    n_vec++; if (v !== 32'h28) begin n_err++; $display("FAIL jalr_link: got %h want %h", v, 32'h28); end
  endtask

  task automatic test_illegal();
    logic [31:0] v;
    do_reset();
    run(enc_i(OP_ADDI, 5'd0, 5'd1, 16'h0077));
    present(enc_i(6'h3F, 5'd0, 5'd1, 16'h1234));
    n_vec++; if (mem_wt_en !== 1'b0 || mem_rd_en !== 1'b0) begin n_err++; $display("FAIL illegal_op_strobes: got wt=%b rd=%b want 0 0", mem_wt_en, mem_rd_en); end
    clock_edge();
    n_vec++; if (PC_out !== 32'h8) begin n_err++; $display("FAIL illegal_op_pc: got %h want %h", PC_out, 32'h8); end
    run(enc_r(6'h3F, 5'd2, 5'd3, 5'd1, 5'd0));
    n_vec++; if (PC_out !== 32'hC) begin n_err++; $display("FAIL illegal_funct_pc: got %h want %h", PC_out, 32'hC); end
    read_reg(5'd1, v);
    n_vec++; if (v !== 32'h77) begin n_err++; $display("FAIL illegal_no_write: got %h want %h", v, 32'h77); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] v;
    do_reset();
    run(enc_i(OP_ADDI, 5'd0, 5'd1, 16'h0055));
    run(enc_i(OP_ADDI, 5'd0, 5'd2, 16'h0066));
    rst = 1'b1;
    present(enc_i(OP_SW, 5'd0, 5'd1, 16'h0010));
    n_vec++; if (mem_wt_en !== 1'b0 || mem_rd_en !== 1'b0) begin n_err++; $display("FAIL rst_strobes: got wt=%b rd=%b want 0 0", mem_wt_en, mem_rd_en); end
    clock_edge();
    rst = 1'b0;
    n_vec++; if (PC_out !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want %h", PC_out, 32'h0); end
    n_vec++; if (dmem[16] !== 8'h00) begin n_err++; $display("FAIL rst_mem_unchanged: got %h want %h", dmem[16], 8'h00); end
    read_reg(5'd1, v);
    n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_r1: got %h want %h", v, 32'h0); end
    read_reg(5'd2, v);
    n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_r2: got %h want %h", v, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_logic_shift();
    test_memory();
    test_branches();
    test_jumps();
    test_illegal();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips32i_single_cycle.md
Name: mips32i_single_cycle

Overview:
- Single-cycle MIPS32 integer CPU core (no delay slots, no exceptions, no coprocessors). Executes one instruction per clock.
- Instruction memory is external and read combinationally via PC_out/inst_in.
- Data memory is external: combinational read, written by the memory on the falling clock edge.
- Memory handles byte-lane selection; the core handles sign-extension and register writeback.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; PC and register file update on rising edge.
- rst  input  1  synchronous, active-high reset.
- inst_in  input  32  instruction at PC_out (combinational from instruction memory).
- data_in  input  32  load data from memory, already lane-shifted to bits [7:0]/[15:0] and zero-extended.
- data_out  output  32  store data; rt value, unshifted (byte in [7:0], half in [15:0]).
- address_out  output  32  byte address = rs + sign_ext(imm16) (ALU result).
- mem_wt_en  output  1  store strobe.
- mem_rd_en  output  1  load strobe.
- mem_size_sel  output  2  access size: 00 byte, 01 halfword, 11 word (10 unused).
- PC_out  output  32  current program counter.

Behaviour:
- Reset: synchronous, active-high. On a rising edge with rst=1: PC<=RESET_PC and all 32 registers <=0.
  - While rst=1, mem_wt_en=0 and mem_rd_en=0; no register write occurs.
- State: PC (32b), register file 32x32.
  - Register reads are combinational.
  - The register write is registered on the rising edge.
  - $0 always reads 0; writes to $0 are discarded.
- Next PC (rising edge), default PC+4:
  - BEQ/BNE/BLEZ/BGTZ taken: PC+4+(sext(imm16)<<2).
  - J/JAL: {PC+4[31:28], index26, 2'b00}.
  - JR/JALR: rs.
  - Not-taken branch: PC+4.
- R-type (opcode 0):
  - ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT (signed), SLTU (unsigned).
  - SLL, SRL, SRA (shift amount = shamt).
  - SLLV, SRLV, SRAV (shift amount = rs[4:0]).
  - JR; JALR (rd<=PC+4).
  - Result is written to rd.
- I-type (result to rt):
  - ADDI, ADDIU, SLTI, SLTIU use sext(imm16). SLTIU compares the sign-extended immediate unsigned.
  - ANDI, ORI, XORI use zext(imm16).
  - LUI: {imm16, 16'h0}.
- JAL: $31<=PC+4.
- Overflow is ignored: ADD/ADDI/SUB behave as ADDU/ADDIU/SUBU (wrap modulo 2^32).
- Loads:
  - LB, LBU, LH, LHU, LW drive mem_rd_en=1, with mem_size_sel 00/00/01/01/11.
  - LB sign-extends data_in[7:0]; LH sign-extends data_in[15:0]; LBU, LHU, LW use data_in as is.
  - The result is written to rt in the same cycle.
- Stores:
  - SB, SH, SW drive mem_wt_en=1, with mem_size_sel 00/01/11 and data_out=rt.
  - Stores do not write registers.
- mem_rd_en and mem_wt_en are 0 for all non-memory instructions. mem_size_sel=11 when idle.
- Misaligned halfword/word addresses are not checked; the memory decides the behaviour.
- Unrecognised opcode/funct: NOP. No register or memory write; PC+4.
- Store-then-load of the same address in consecutive cycles must return the new data, because memory writes on the falling edge.
- PC wraps modulo 2^32.

Test Plan:
- Reset/ALU: rst=1 for one edge, then ADDI $1,$0,5; ADDI $2,$0,-3; ADD $3,$1,$2; SUB $4,$2,$1.
  -> PC_out=0 after reset; $3=2, $4=0xFFFFFFF8; SLT $5,$2,$1 -> 1; SLTU $6,$2,$1 -> 0.
- Logic/shift: ORI $1,$0,0x8000; LUI $2,0x8000; SRA $3,$2,4; SRL $4,$2,4; NOR $5,$0,$0.
  -> $1=0x00008000, $3=0xF8000000, $4=0x08000000, $5=0xFFFFFFFF; ADDI $0,$0,7 leaves $0=0.
- Memory: $1=0x12345687; SW $1,0($0); LB $2,0($0); LBU $3,0($0); LH $4,2($0); SB $1,5($0); LW $5,4($0).
  -> $2=0xFFFFFF87, $3=0x00000087, $4=0x00001234, $5=0x00008700.
  -> During SW: mem_wt_en=1, size=11, address_out=0.
- Branches: BEQ taken at PC=0x10 with imm=2 -> PC=0x1C.
  -> BNE not taken -> PC+4; BLEZ on 0 taken; BGTZ on 0 not taken.
- Jumps: JAL at PC=0x20 with index 0x40 -> PC=0x100, $31=0x24.
  -> JR $31 -> PC=0x24; JALR $5,$31 -> rd=PC+4.
- Mid-run reset: assert rst while executing SW.
  -> mem_wt_en=0, memory unchanged; next edge PC=0 and all registers 0.
